// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one 8-beat AXI4 INCR read per miss,
// then a single-cycle refresh pulse carrying the assembled line.
module icache_refill #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'b0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss,
  input  logic [31:0]               axi_addr,
  output logic                      refresh,
  output logic [32*LINE_WORDS-1:0]  line_data,
  output logic                      bus_err,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t                          state, state_nxt;
  logic [2:0]                      cnt;
  logic                            err;
  logic [LINE_WORDS-1:0][31:0]     line_q;
  logic                            last_beat;
  logic                            unused_rid;

  assign arid       = AXI_ID;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign line_data  = line_q;
  assign last_beat  = (cnt == 3'(LINE_WORDS - 1));
  assign unused_rid = ^rid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs are decoded from state alone, so no input reaches an output.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    refresh   = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: if (miss) state_nxt = AR;
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid && last_beat) state_nxt = DONE;
      end
      DONE: begin
        refresh   = 1'b1;
        bus_err   = err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      line_q <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          araddr <= axi_addr;
          err    <= 1'b0;
        end
        AR: if (arready) cnt <= '0;
        R: if (rvalid) begin
          line_q[cnt] <= rdata;
          cnt         <= cnt + 3'd1;
          // Burst length is fixed by beat count; a misplaced rlast only flags an error.
          if (rresp != 2'b00 || rlast != last_beat) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Line-refill engine for the instruction cache: the AXI-facing end of the tag array's miss request. On `miss` it captures the line-aligned `axi_addr` and issues one 8-beat AXI4 INCR read burst. It collects the 256-bit line and pulses `refresh`, with `line_data`, so tag and data arrays are written in the same cycle. It sits between the cache tag/data arrays and the AXI read channels of the core's bus interface.

## Interface
- `LINE_WORDS`, 8, words per line; fixed by the 5-bit offset (32-byte lines).
- `AXI_ID`, 4'b0000, constant ARID for instruction fetch.

- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `miss` input 1: refill request from the tag array, level-sensitive.
- `axi_addr` input 32: line-aligned refill address, with bits [4:0] = 0.
- `refresh` output 1: one-cycle pulse that writes the new tag and `line_data`.
- `line_data` output 256: refilled line. Word i is at [32i+31:32i]; word 0 is at the lowest address.
- `bus_err` output 1: pulses with `refresh` if the burst was malformed or errored.
- `arid` output 4: `AXI_ID`, constant.
- `araddr` output 32: latched refill address.
- `arlen` output 8: constant 8'd7.
- `arsize` output 3: constant 3'b010.
- `arburst` output 2: constant 2'b01 (INCR).
- `arvalid` output 1: read address valid.
- `arready` input 1: read address ready.
- `rid` input 4: ignored.
- `rdata` input 32: read beat data.
- `rresp` input 2: read beat response.
- `rlast` input 1: last beat of the burst.
- `rvalid` input 1: read beat valid.
- `rready` output 1: read beat ready.

## Operation
- FSM states: IDLE, AR, R, DONE. All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- IDLE:
  - `arvalid`=0, `rready`=0.
  - If `miss`=1: latch `axi_addr` into `araddr` and go to AR.
- AR:
  - `arvalid`=1 and `araddr` is held stable.
  - `arvalid` never drops before handshake.
  - On `arvalid`&`arready`: clear the 3-bit beat counter and go to R.
- R:
  - `rready`=1.
  - Each `rvalid`&`rready` beat writes `rdata` into word[cnt], then cnt+1.
  - The beat accepted with cnt==7 moves the FSM to DONE.
  - Completion is counted by beats only; `rlast` does not end the burst early.
- DONE:
  - `refresh`=1 for exactly one cycle, then go to IDLE.
- Error flag:
  - A sticky internal error is set on any accepted beat with `rresp`≠0.
  - It is also set on any beat where `rlast` ≠ (cnt==7).
  - `bus_err` = error flag in DONE; the flag clears on entering AR.
- `miss` is ignored outside IDLE.
- `rvalid` outside R is not accepted (`rready`=0).
- `line_data` is valid in DONE. It holds its value until overwritten by the first beat of the next refill.
- Reset:
  - Forces IDLE immediately.
  - Clears `arvalid`, `rready`, `refresh`, `bus_err`, `araddr`, `line_data`, the counter and the error flag to 0.
  - A burst in flight is abandoned; no `refresh` is issued for it.

## Timing
- Zero-wait slave: `miss` high in cycle 0, then:
  - `arvalid` is high in cycle 1 with `arready`=1.
  - Beats arrive in cycles 2–9.
  - `refresh` pulses in cycle 10.
  - Miss-to-refresh latency is 10 cycles.
- Each AR wait cycle and each R bubble cycle adds exactly one cycle.
- The tag is written at the edge ending DONE. `miss` deasserts for the same address in the following cycle, and the FSM is in IDLE by then, so no duplicate refill occurs.
- Back-to-back misses at different addresses: the next `arvalid` appears at the earliest 2 cycles after `refresh`.
- Constant AR fields are valid out of reset.

## Test plan
- **Basic refill.** `miss`=1, `axi_addr`=0xBFC0_0020, zero-wait slave returning 0x11111111..0x88888888 with `rlast` on beat 8 → `araddr`=0xBFC00020, `arlen`=7, `arsize`=2, `arburst`=1. Then `refresh` is a single pulse in cycle 10 with `line_data`[31:0]=0x11111111 and [255:224]=0x88888888, `bus_err`=0.
- **AR backpressure.** `arready` is held low 5 cycles → `arvalid` stays high and `araddr` stays stable for those cycles; `refresh` arrives in cycle 15.
- **R bubbles.** `rvalid` deasserts between every beat → all 8 words are captured in order, with no duplicate or skipped word; `refresh` arrives once.
- **Errors.** `rresp`=2'b10 on beat 3 → `bus_err`=1 together with `refresh`. A following clean refill gives `bus_err`=0. `rlast` asserted on beat 5 → the burst still completes after 8 beats and `bus_err`=1.
- **Reset mid-burst.** Assert `rst` after beat 4 → in the same cycle, `rready`=0, `arvalid`=0, `line_data`=0, and no `refresh` follows. After release, a new `miss` produces a normal 10-cycle refill.
- **Stale miss.** `miss` is toggled while in AR or R → exactly one AR handshake per refill, using the originally latched address.
